vga_scan_out: RTL and testbench

Pixel-side consumer for the 1-bit VGA path. It pops 16-bit pixel words from the show-ahead FIFO that the DMA read engine fills, and shifts them out MSB-first as 1-bit pixels. It also generates the horizontal and vertical sync and blanking timing and flags FIFO underflow and vertical-blank start back to the control side. Everything runs in a single clock domain; the pixel rate is the clock divided by CLK_DIV.

---
 rtl/vga_scan_out.sv | 166 ++++++++++++++++
 tb/tb_vga_scan_out.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// vga_scan_out: 1-bit VGA pixel scan-out. Pops 16-bit words from a show-ahead
// FIFO, shifts them out MSB-first at clk/CLK_DIV, and generates hsync, vsync
// and blanking together with vblank-start and sticky underflow flags.
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] fifo_readdata,
  input  logic        fifo_empty,
  output logic        fifo_read,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_pixel,
  output logic        vga_blank_n,
  output logic        vblank_start,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra count of headroom so the sync-end compare constant always fits.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [15:0]   shreg;

  logic        tick;
  logic        active;
  logic        load;
  logic        hs_i;
  logic        vs_i;
  logic [15:0] load_word;

  // Pixel-rate strobe, position decode and FIFO pop, all from registered state.
  always_comb begin
    tick      = enable & (div == DIV_LAST);
    active    = (h < H_ACT) & (v < V_ACT);
    load      = tick & active & (h[3:0] == 4'd0);
    fifo_read = load & ~fifo_empty;
    load_word = fifo_empty ? 16'h0000 : fifo_readdata;
    hs_i      = ~((h >= H_SYNC_BEG) & (h < H_SYNC_END));
    vs_i      = ~((v >= V_SYNC_BEG) & (v < V_SYNC_END));
  end

  // Clock divider: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (!enable) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Horizontal/vertical position counters; v steps on the h wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (!enable) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) begin
          v <= '0;
        end else begin
          v <= v + VW'(1);
        end
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  // Pixel shift register: loads on 16-pixel boundaries, shifts on other active ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (!enable) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_word;
    end else if (tick & active) begin
      shreg <= {shreg[14:0], 1'b0};
    end
  end

  // Registered video outputs, updated once per pixel and idle while disabled.
  // On a shift tick the displayed bit is shreg[14], i.e. bit 15 after the shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_pixel   <= 1'b0;
      vga_blank_n <= 1'b0;
    end else if (!enable) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_pixel   <= 1'b0;
      vga_blank_n <= 1'b0;
    end else if (tick) begin
      vga_hs      <= hs_i;
      vga_vs      <= vs_i;
      vga_blank_n <= active;
      if (load) begin
        vga_pixel <= load_word[15];
      end else if (active) begin
        vga_pixel <= shreg[14];
      end else begin
        vga_pixel <= 1'b0;
      end
    end
  end

  // One-clk pulse on the tick that ends the last active line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_start <= 1'b0;
    end else begin
      vblank_start <= tick & (h == H_LAST) & (v == V_ACT_LAST);
    end
  end

  // Sticky underflow: set on a load from an empty FIFO, set beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
    end else if (load & fifo_empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: directed bench for vga_scan_out with a pixel-index based
// reference model checked every cycle, plus hand-computed literal expectations.
module tb_vga_scan_out;

  localparam int HA = 32, HF = 2, HS = 4, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int CD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NLOG = 1281;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] fifo_readdata = 16'hA5F0;
  logic        fifo_empty = 1'b0;
  logic        underflow_clr = 1'b0;
  logic        fifo_read;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_pixel;
  logic        vga_blank_n;
  logic        vblank_start;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .fifo_readdata(fifo_readdata),
    .fifo_empty(fifo_empty),
    .fifo_read(fifo_read),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_pixel(vga_pixel),
    .vga_blank_n(vga_blank_n),
    .vblank_start(vblank_start),
    .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: n counts enabled clk edges since enable was last seen low;
  // every CD-th edge displays pixel index n/CD-1 of an endless raster.
  int unsigned n = 0;
  logic [15:0] m_word = '0;
  logic e_hs = 1'b1, e_vs = 1'b1, e_pix = 1'b0, e_blank = 1'b0, e_vb = 1'b0, e_uf = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    int unsigned p, hh, vv;
    logic act, ld;
    if (!reset_n) begin
      n = 0; m_word = '0;
      e_hs = 1'b1; e_vs = 1'b1; e_pix = 1'b0; e_blank = 1'b0; e_vb = 1'b0; e_uf = 1'b0;
    end else begin
      ld = 1'b0;
      e_vb = 1'b0;
      if (!enable) begin
        n = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_pix = 1'b0; e_blank = 1'b0;
      end else begin
        n++;
        if (n % CD == 0) begin
          p  = n / CD - 1;
          hh = p % HT;
          vv = (p / HT) % VT;
          act = (hh < HA) && (vv < VA);
          if (act && (hh % 16 == 0)) begin
            ld = 1'b1;
            m_word = fifo_empty ? 16'h0000 : fifo_readdata;
          end
          e_pix   = act ? m_word[15 - (hh % 16)] : 1'b0;
          e_blank = act;
          e_hs    = !((hh >= HA + HF) && (hh < HA + HF + HS));
          e_vs    = !((vv >= VA + VF) && (vv < VA + VF + VS));
          e_vb    = (hh == HT - 1) && (vv == VA - 1);
        end
      end
      if (ld && fifo_empty) e_uf = 1'b1;
      else if (underflow_clr) e_uf = 1'b0;
    end
  end

  function automatic logic exp_rd();
    int unsigned m, p, hh, vv;
    if (!reset_n || !enable || fifo_empty) return 1'b0;
    m = n + 1;
    if (m % CD != 0) return 1'b0;
    p  = m / CD - 1;
    hh = p % HT;
    vv = (p / HT) % VT;
    return (hh < HA) && (vv < VA) && (hh % 16 == 0);
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("hs", vga_hs, e_hs);
    chk("vs", vga_vs, e_vs);
    chk("pixel", vga_pixel, e_pix);
    chk("blank_n", vga_blank_n, e_blank);
    chk("vblank_start", vblank_start, e_vb);
    chk("underflow", underflow, e_uf);
    chk("fifo_read", fifo_read, exp_rd());
  end

  bit lg_hs[NLOG], lg_vs[NLOG], lg_px[NLOG], lg_bl[NLOG], lg_vb[NLOG], lg_rd[NLOG], lg_uf[NLOG];

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  // Log outputs at negedge i (after i enabled edges); optional mid-run actions.
  task automatic log_run(input int last, input int refill_at, input int clr_on_at, input int clr_off_at);
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      lg_hs[i] = vga_hs; lg_vs[i] = vga_vs; lg_px[i] = vga_pixel; lg_bl[i] = vga_blank_n;
      lg_vb[i] = vblank_start; lg_rd[i] = fifo_read; lg_uf[i] = underflow;
      if (i == refill_at || i == clr_on_at || i == clr_off_at) begin
        drive_edge();
        if (i == refill_at) begin fifo_empty = 1'b0; fifo_readdata = 16'hC3C3; end
        if (i == clr_on_at) underflow_clr = 1'b1;
        if (i == clr_off_at) underflow_clr = 1'b0;
      end
    end
  endtask

  function automatic int count_ones(input int which, input int lo, input int hi, input bit val);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      bit b;
      case (which)
        0: b = lg_hs[i];
        1: b = lg_vs[i];
        2: b = lg_bl[i];
        3: b = lg_vb[i];
        default: b = lg_rd[i];
      endcase
      if (b == val) c++;
    end
    return c;
  endfunction

  initial begin
    logic [15:0] pat_a;
    int first_low;
    pat_a = 16'b1010010111110000;

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    chk("rst_hs", vga_hs, 1'b1);
    chk("rst_vs", vga_vs, 1'b1);
    chk("rst_pixel", vga_pixel, 1'b0);
    chk("rst_blank_n", vga_blank_n, 1'b0);
    chk("rst_vblank", vblank_start, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_fifo_read", fifo_read, 1'b0);
    #9 reset_n = 1'b1;

    // Two full frames with a constantly full FIFO
    drive_edge();
    enable = 1'b1;
    log_run(1280, -1, -1, -1);
    for (int k = 0; k < 32; k++) chk("line0_pixel", lg_px[2 * k + 2], pat_a[15 - (k % 16)]);
    chk_int("blank_clk_line0", count_ones(2, 2, 81, 1'b1), 64);
    chk_int("blank_clk_line1", count_ones(2, 82, 161, 1'b1), 64);
    first_low = -1;
    for (int i = 81; i >= 0; i--) if (!lg_hs[i]) first_low = i;
    chk_int("hs_low_start", first_low - 2, 68);
    chk_int("hs_low_clk", count_ones(0, 2, 81, 1'b0), 8);
    chk_int("vs_low_clk", count_ones(1, 2, 641, 1'b0), 160);
    chk("vs_line4", lg_vs[401], 1'b1);
    chk("vs_line5", lg_vs[402], 1'b0);
    chk("vs_line6", lg_vs[561], 1'b0);
    chk("vs_line7", lg_vs[562], 1'b1);
    chk("vblank_f0", lg_vb[320], 1'b1);
    chk("vblank_f1", lg_vb[960], 1'b1);
    chk_int("vblank_count", count_ones(3, 0, 1280, 1'b1), 2);
    chk("first_pop_wait", lg_rd[0], 1'b0);
    chk("first_pop", lg_rd[1], 1'b1);
    chk_int("pops_f0", count_ones(4, 0, 640, 1'b1), 8);
    chk_int("pops_f1", count_ones(4, 641, 1280, 1'b1), 8);

    // Enable dropped mid-line, then re-enabled
    repeat (20) @(posedge clk);
    #2;
    chk("pre_drop_blank_n", vga_blank_n, 1'b1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_hs", vga_hs, 1'b1);
    chk("drop_vs", vga_vs, 1'b1);
    chk("drop_blank_n", vga_blank_n, 1'b0);
    chk("drop_pixel", vga_pixel, 1'b0);
    chk("drop_fifo_read", fifo_read, 1'b0);
    #1 enable = 1'b1;
    @(negedge clk);
    chk("reen_pop_wait", fifo_read, 1'b0);
    @(negedge clk);
    chk("reen_pop", fifo_read, 1'b1);

    // Underflow at the first word, refill mid-group, then clear
    drive_edge();
    enable = 1'b0;
    fifo_empty = 1'b1;
    drive_edge();
    enable = 1'b1;
    log_run(80, 10, -1, -1);
    chk("uf_before_load", lg_uf[1], 1'b0);
    chk("uf_after_load", lg_uf[2], 1'b1);
    chk("uf_no_pop", lg_rd[1], 1'b0);
    for (int k = 0; k < 16; k++) chk("uf_pixel_zero", lg_px[2 * k + 2], 1'b0);
    chk("refill_pop", lg_rd[33], 1'b1);
    chk("refill_p16", lg_px[34], 1'b1);
    chk("refill_p17", lg_px[36], 1'b1);
    chk("refill_p18", lg_px[38], 1'b0);
    chk("refill_p22", lg_px[46], 1'b1);
    chk("uf_sticky", underflow, 1'b1);
    drive_edge();
    underflow_clr = 1'b1;
    drive_edge();
    underflow_clr = 1'b0;
    chk("uf_cleared", underflow, 1'b0);

    // Clear coinciding with an empty load: set wins
    drive_edge();
    enable = 1'b0;
    drive_edge();
    enable = 1'b1;
    fifo_empty = 1'b1;
    log_run(40, -1, 20, 36);
    chk("uf_set2", lg_uf[2], 1'b1);
    chk("uf_clr_mid", lg_uf[33], 1'b0);
    chk("uf_set_wins", lg_uf[34], 1'b1);
    chk("uf_clr_after", lg_uf[35], 1'b0);

    // Asynchronous reset mid-frame
    repeat (50) @(posedge clk);
    #2;
    chk("uf_pre_reset", underflow, 1'b1);
    #1 reset_n = 1'b0;
    fifo_empty = 1'b0;
    fifo_readdata = 16'hA5F0;
    #1;
    chk("arst_hs", vga_hs, 1'b1);
    chk("arst_vs", vga_vs, 1'b1);
    chk("arst_pixel", vga_pixel, 1'b0);
    chk("arst_blank_n", vga_blank_n, 1'b0);
    chk("arst_vblank", vblank_start, 1'b0);
    chk("arst_underflow", underflow, 1'b0);
    chk("arst_fifo_read", fifo_read, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pop_wait", fifo_read, 1'b0);
    @(negedge clk);
    chk("post_rst_pop", fifo_read, 1'b1);
    @(negedge clk);
    chk("post_rst_blank_n", vga_blank_n, 1'b1);
    chk("post_rst_pixel", vga_pixel, 1'b1);

    repeat (100) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
